// File: rtl/round_key_store_if.sv
// Bus between the key-expansion/cipher side and the round key store.
// master drives captures and read requests; slave is the store.
interface round_key_store_if;
    logic         load_start;
    logic         rk_valid;
    logic [127:0] rk_in;
    logic         rd_en;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    logic         rd_valid;
    logic         ready;
    logic         busy;
    logic         err;

    modport master (
        output load_start, rk_valid, rk_in, rd_en, rd_idx,
        input  rd_key, rd_valid, ready, busy, err
    );

    modport slave (
        input  load_start, rk_valid, rk_in, rd_en, rd_idx,
        output rd_key, rd_valid, ready, busy, err
    );
endinterface

// File: rtl/round_key_store.sv
// Stores one AES-256 round key schedule as it streams out of key expansion
// and serves registered single-cycle-latency reads to the cipher core.
module round_key_store #(
    parameter int unsigned NUM_RK = 15
) (
    input logic              clk,
    input logic              rst,
    round_key_store_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StFill, StReady} state_t;

    localparam logic [3:0] LastIdx = 4'(NUM_RK - 1);

    state_t       state_q, state_d;
    logic [3:0]   wr_cnt_q, wr_cnt_d;
    logic         err_q, err_d;
    logic [127:0] rd_key_q, rd_key_d;
    logic         rd_valid_q, rd_valid_d;
    logic         mem_we;
    logic [3:0]   mem_waddr;

    logic [127:0] mem [NUM_RK];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            wr_cnt_q   <= '0;
            err_q      <= 1'b0;
            rd_key_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            err_q      <= err_d;
            rd_key_q   <= rd_key_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        err_d      = err_q;
        rd_key_d   = rd_key_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = wr_cnt_q;

        if (bus.load_start) begin
            // Restart from any state; a coincident beat becomes entry 0.
            state_d   = StFill;
            wr_cnt_d  = '0;
            err_d     = 1'b0;
            mem_waddr = '0;
            if (bus.rk_valid) begin
                mem_we   = 1'b1;
                wr_cnt_d = 4'd1;
                if (LastIdx == 4'd0) state_d = StReady;
            end
        end else begin
            case (state_q)
                StFill: begin
                    if (bus.rk_valid) begin
                        mem_we   = 1'b1;
                        wr_cnt_d = wr_cnt_q + 4'd1;
                        if (wr_cnt_q == LastIdx) state_d = StReady;
                    end
                end
                StReady: begin
                    if (bus.rk_valid) err_d = 1'b1;
                end
                default: ;
            endcase
        end

        // Reads are judged on the current state, so a read on the final
        // write edge still sees FILL and is rejected.
        if (bus.rd_en) begin
            if (state_q == StReady && bus.rd_idx <= LastIdx) begin
                rd_key_d   = mem[bus.rd_idx];
                rd_valid_d = 1'b1;
            end else begin
                rd_key_d = '0;
                err_d    = 1'b1;
            end
        end
    end

    // Storage is deliberately unreset; the read path gates it on READY.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= bus.rk_in;
    end

    assign bus.rd_key   = rd_key_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.ready    = (state_q == StReady);
    assign bus.busy     = (state_q == StFill);
    assign bus.err      = err_q;
endmodule

// File: tb/tb_round_key_store.sv
// Directed and randomized checks of round_key_store against a transaction-level
// model of the schedule store.
module tb_round_key_store;
    localparam int NRK = 15;
    localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K1  = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] K14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    round_key_store_if bus ();

    round_key_store #(.NUM_RK(NRK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: phase 0 = idle, 1 = capturing, 2 = schedule readable.
    int           m_phase;
    int           m_cnt;
    logic [127:0] m_mem [NRK];
    logic         m_err;
    logic [127:0] m_key;
    logic         m_rv;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] key_a [NRK];
    logic [127:0] key_b [NRK];

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".rd_valid"}, 128'(bus.rd_valid), 128'(m_rv));
        check({tag, ".rd_key"}, bus.rd_key, m_key);
        check({tag, ".ready"}, 128'(bus.ready), 128'(m_phase == 2));
        check({tag, ".busy"}, 128'(bus.busy), 128'(m_phase == 1));
        check({tag, ".err"}, 128'(bus.err), 128'(m_err));
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_cnt   = 0;
        m_err   = 1'b0;
        m_key   = '0;
        m_rv    = 1'b0;
    endtask

    // One clock cycle: drive, apply the model's rules, compare #1 after the edge.
    task automatic step(input string tag, input logic ls, input logic v, input logic [127:0] k,
                        input logic re, input logic [3:0] idx);
        logic new_err;
        bus.load_start = ls;
        bus.rk_valid   = v;
        bus.rk_in      = k;
        bus.rd_en      = re;
        bus.rd_idx     = idx;
        @(posedge clk);
        new_err = 1'b0;
        m_rv    = 1'b0;
        if (re) begin
            if (m_phase == 2 && int'(idx) < NRK) begin
                m_key = m_mem[idx];
                m_rv  = 1'b1;
            end else begin
                m_key   = '0;
                new_err = 1'b1;
            end
        end
        if (ls) begin
            m_err   = 1'b0;
            m_phase = 1;
            m_cnt   = 0;
            if (v) begin
                m_mem[0] = k;
                m_cnt    = 1;
            end
        end else if (v && m_phase == 1) begin
            m_mem[m_cnt] = k;
            m_cnt++;
            if (m_cnt == NRK) m_phase = 2;
        end else if (v && m_phase == 2) begin
            new_err = 1'b1;
        end
        m_err = m_err | new_err;
        #1;
        check_outputs(tag);
    endtask

    initial begin
        bus.load_start = 1'b0;
        bus.rk_valid   = 1'b0;
        bus.rk_in      = '0;
        bus.rd_en      = 1'b0;
        bus.rd_idx     = '0;
        model_reset();
        for (int i = 0; i < NRK; i++) begin
            key_a[i] = rand128();
            key_b[i] = rand128();
        end
        key_a[0]  = K0;
        key_a[1]  = K1;
        key_a[14] = K14;

        // Reset state
        #12;
        check_outputs("reset");
        #1 rst = 1'b1;

        // Read in IDLE is rejected and flags err; load_start clears it
        step("idle_rd", 1'b0, 1'b0, '0, 1'b1, 4'd0);
        check("idle_rd_err", 128'(bus.err), 128'(1));
        step("clr_ls", 1'b1, 1'b0, '0, 1'b0, 4'd0);
        check("clr_ls_err", 128'(bus.err), 128'(0));

        // Full capture of the reference schedule
        for (int i = 0; i < NRK; i++) step("fill_a", 1'b0, 1'b1, key_a[i], 1'b0, 4'd0);
        check("ready_after_15", 128'(bus.ready), 128'(1));
        step("rd0", 1'b0, 1'b0, '0, 1'b1, 4'd0);
        check("rd0_const", bus.rd_key, K0);
        step("rd1", 1'b0, 1'b0, '0, 1'b1, 4'd1);
        check("rd1_const", bus.rd_key, K1);
        step("rd14", 1'b0, 1'b0, '0, 1'b1, 4'd14);
        check("rd14_const", bus.rd_key, K14);
        step("hold", 1'b0, 1'b0, '0, 1'b0, 4'd3);
        check("hold_key", bus.rd_key, K14);

        // Back-to-back reads 14 down to 0
        for (int i = NRK - 1; i >= 0; i--) begin
            step("b2b", 1'b0, 1'b0, '0, 1'b1, 4'(i));
            check("b2b_valid", 128'(bus.rd_valid), 128'(1));
        end
        check("b2b_err", 128'(bus.err), 128'(0));

        // Abandon after 7 beats, then capture a different schedule
        step("ls_a", 1'b1, 1'b0, '0, 1'b0, 4'd0);
        for (int i = 0; i < 7; i++) step("part_a", 1'b0, 1'b1, key_a[i], 1'b0, 4'd0);
        step("ls_b", 1'b1, 1'b0, '0, 1'b0, 4'd0);
        for (int i = 0; i < NRK; i++) step("fill_b", 1'b0, 1'b1, key_b[i], 1'b0, 4'd0);
        for (int i = 0; i < NRK; i++) begin
            step("rd_b", 1'b0, 1'b0, '0, 1'b1, 4'(i));
            check("rd_b_const", bus.rd_key, key_b[i]);
        end
        check("b_err", 128'(bus.err), 128'(0));

        // Protocol errors: read during fill, read on final write edge,
        // out-of-range index, extra beat in READY; err sticks until load_start
        step("ls_e", 1'b1, 1'b0, '0, 1'b0, 4'd0);
        step("fill_rd", 1'b0, 1'b1, key_a[0], 1'b1, 4'd0);
        check("fill_rd_err", 128'(bus.err), 128'(1));
        for (int i = 1; i < NRK - 1; i++) step("fill_e", 1'b0, 1'b1, key_a[i], 1'b0, 4'd0);
        step("last_wr_rd", 1'b0, 1'b1, key_a[NRK-1], 1'b1, 4'd2);
        check("last_wr_rd_valid", 128'(bus.rd_valid), 128'(0));
        step("idx15", 1'b0, 1'b0, '0, 1'b1, 4'd15);
        check("idx15_key", bus.rd_key, 128'(0));
        step("beat16", 1'b0, 1'b1, rand128(), 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) step("err_hold", 1'b0, 1'b0, '0, 1'b0, 4'd0);
        check("err_sticky", 128'(bus.err), 128'(1));
        step("ls_clr", 1'b1, 1'b0, '0, 1'b0, 4'd0);

        // load_start coincident with the first beat
        step("ls_beat", 1'b1, 1'b1, K0, 1'b0, 4'd0);
        for (int i = 1; i < NRK; i++) step("fill_c", 1'b0, 1'b1, key_a[i], 1'b0, 4'd0);
        step("rd_c0", 1'b0, 1'b0, '0, 1'b1, 4'd0);
        check("rd_c0_const", bus.rd_key, K0);

        // Asynchronous reset mid-fill, then beats without load_start are ignored
        step("pre_rst_rd", 1'b0, 1'b0, '0, 1'b1, 4'd5);
        step("ls_r", 1'b1, 1'b0, '0, 1'b0, 4'd0);
        for (int i = 0; i < 10; i++) step("fill_r", 1'b0, 1'b1, key_b[i], 1'b0, 4'd0);
        #3 rst = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        #2 rst = 1'b1;
        for (int i = 0; i < NRK + 2; i++) step("post_rst", 1'b0, 1'b1, rand128(), 1'b0, 4'd0);
        check("post_rst_ready", 128'(bus.ready), 128'(0));

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic ls, v, re;
            ls = ($urandom_range(99, 0) < 4);
            v  = ($urandom_range(99, 0) < 70);
            re = ($urandom_range(99, 0) < 40);
            step("rand", ls, v, rand128(), re, 4'($urandom_range(15, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/round_key_store.md
ROUND_KEY_STORE -- requirements
Module: round_key_store

Interface
REQ-001 SHALL have parameter NUM_RK, default 15, number of 128-bit round keys per AES-256 schedule.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port load_start  input  1  one-cycle pulse: new key expansion begins, discard stored schedule.
REQ-005 SHALL have port rk_valid  input  1  rk_in carries the next round key this cycle.
REQ-006 SHALL have port rk_in  input  128  round key from key expansion, round 0 first.
REQ-007 SHALL have port rd_en  input  1  read request from cipher core.
REQ-008 SHALL have port rd_idx  input  4  round index to read, 0..NUM_RK-1.
REQ-009 SHALL have port rd_key  output  128  registered read data.
REQ-010 SHALL have port rd_valid  output  1  rd_key valid this cycle.
REQ-011 SHALL have port ready  output  1  full schedule stored and readable.
REQ-012 SHALL have port busy  output  1  capture in progress.
REQ-013 SHALL have port err  output  1  sticky protocol error flag.

Function
REQ-014 SHALL implement FSM states IDLE, FILL, READY; busy=1 only in FILL, ready=1 only in READY.
REQ-015 IDLE/READY/FILL + load_start SHALL go to FILL, clear write counter wr_cnt to 0, clear ready.
REQ-016 In FILL, each rk_valid cycle SHALL write rk_in to entry wr_cnt and increment wr_cnt (4-bit).
REQ-017 Write of entry NUM_RK-1 SHALL transition FILL->READY on the same edge; ready=1 the following cycle.
REQ-018 load_start and rk_valid in the same cycle SHALL restart and store rk_in as entry 0, wr_cnt=1.
REQ-019 rk_valid in IDLE SHALL be ignored with no error; rk_valid in READY without load_start SHALL be ignored and set err.
REQ-020 load_start during FILL SHALL abandon the partial schedule and restart at entry 0 without error.
REQ-021 Read: rd_en in READY with rd_idx<NUM_RK SHALL give rd_key=entry[rd_idx], rd_valid=1 exactly one cycle later.
REQ-022 rd_en in IDLE/FILL, or rd_idx>=NUM_RK, SHALL give rd_valid=0, rd_key=0 next cycle, and set err.
REQ-023 rd_valid SHALL be a one-cycle pulse per accepted rd_en; back-to-back rd_en SHALL be accepted every cycle.
REQ-024 rd_key SHALL hold its last value when rd_en=0; rd_valid SHALL be 0.
REQ-025 Read and write in the same cycle (rd_en in the cycle FILL->READY) SHALL be rejected per REQ-022 (state is FILL at that edge).
REQ-026 err SHALL remain set until reset or load_start.
REQ-027 Storage SHALL be NUM_RK x 128 registers; entries are not cleared by load_start, only made unreadable.

Reset
REQ-028 rst=0 SHALL asynchronously force state IDLE, wr_cnt=0, rd_key=0, rd_valid=0, ready=0, busy=0, err=0.
REQ-029 Storage array SHALL NOT require reset; outputs SHALL never expose it before READY.
REQ-030 Reset asserted mid-FILL SHALL discard the partial schedule; after release block waits in IDLE for load_start.

Verification
REQ-031 Key 000102..1f: load_start, 15 rk_valid beats from key expansion -> ready=1 one cycle after 15th beat; rd_idx=0 -> rd_key=000102030405060708090a0b0c0d0e0f; rd_idx=1 -> 101112131415161718191a1b1c1d1e1f; rd_idx=14 -> 24fc79ccbf0979e9371ac23c6d68de36, each with 1-cycle latency.
REQ-032 Reads idx 14,13..0 on 15 consecutive cycles -> 15 consecutive rd_valid pulses with matching data, err=0.
REQ-033 load_start after 7 beats, then 15 fresh beats of a different key -> entries 0..14 equal the second key's schedule, err=0.
REQ-034 rd_en before ready, then rd_idx=15 in READY, then 16th rk_valid in READY -> rd_valid=0, rd_key=0, err=1 and held until next load_start.
REQ-035 rst=0 asserted after 10 beats -> all outputs 0 immediately (asynchronous); after release, rk_valid alone is ignored, ready stays 0.
REQ-036 load_start coincident with rk_valid carrying 000102..0f -> entry 0 equals that value, 14 further beats reach READY.
